hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Parameter: REG_ADDR_W, default 5, register index width.
REQ-003 Parameter: CNT_W, default 16, stall-counter width.
REQ-004 clk  in  1  sole clock; all state updates on the rising edge.
REQ-005 rst  in  1  asynchronous, active-low reset.
REQ-006 rs1D  in  REG_ADDR_W  source 1 index of the instruction in Decode.
REQ-007 rs2D  in  REG_ADDR_W  source 2 index of the instruction in Decode.
REQ-008 rdD  in  REG_ADDR_W  destination index of the instruction in Decode.
REQ-009 RegWriteD  in  1  Decode instruction writes the register file.
REQ-010 ResultSrcD  in  1  Decode instruction is a load.
REQ-011 PCSrcE  in  1  branch/jump taken, resolved in Execute.
REQ-012 MemReady  in  1  data memory can complete this cycle; 0 freezes the pipe.
REQ-013 StallF, StallD  out  1 each  hold PC and the F/D register.
REQ-014 StallE, StallM, StallW  out  1 each  hold the D/E, E/M and M/W registers.
REQ-015 FlushD, FlushE  out  1 each  clear F/D and D/E to bubbles.
REQ-016 ForwardAE, ForwardBE  out  2 each  ALU operand source: 00 = register file, 10 = ALUResultM, 01 = Result (W).
REQ-017 StallCount  out  CNT_W  saturating count of stalled cycles.

Function
REQ-018 The module SHALL hold internal shadow tags mirroring the pipeline: E {rs1, rs2, rd, regwrite, load}, M {rd, regwrite}, W {rd, regwrite}.
REQ-019 Normal advance: D inputs go to shadow E, E to M, M to W, each rising edge.
REQ-020 Load-use stall: raise StallF = StallD = 1 and FlushE = 1 when shadow E load = 1, E rd != 0, and E rd equals rs1D or rs2D.
REQ-021 During a load-use stall, shadow E SHALL load a bubble (regwrite = 0, load = 0, rd = 0); E advances to M normally.
REQ-022 Branch flush: PCSrcE = 1 SHALL assert FlushD = 1 and FlushE = 1, and shadow E SHALL load a bubble.
REQ-023 PCSrcE = 1 together with a load-use condition: flush wins; StallF = StallD = 0, because the stalling instruction is squashed.
REQ-024 Forwarding for operand A: ForwardAE = 10 if M regwrite and M rd != 0 and M rd == E rs1.
REQ-025 Otherwise ForwardAE = 01 if the same condition holds against W.
REQ-026 Otherwise ForwardAE = 00.
REQ-027 ForwardBE SHALL follow the same rules as REQ-024 to REQ-026, using E rs2.
REQ-028 M has priority over W when both match.
REQ-029 Register x0 SHALL never cause a stall or a forward.
REQ-030 No hazard SHALL be raised between a W writer and a D reader, because the register file writes before Decode reads within the cycle.
REQ-031 Memory freeze: MemReady = 0 SHALL assert all five Stall outputs and force FlushD = FlushE = 0.
REQ-032 During a memory freeze all shadow tags hold and ForwardAE/BE hold their current values.
REQ-033 A PCSrcE or load-use condition present during a freeze SHALL take effect in the first cycle after MemReady returns to 1.
REQ-034 StallCount SHALL increment by 1 in each cycle where StallD = 1 for any cause.
REQ-035 StallCount SHALL saturate at all-ones and never wrap.
REQ-036 All stall, flush and forward outputs SHALL be combinational from the shadow tags and current inputs, with zero-cycle latency.

Reset
REQ-037 While rst = 0, all shadow tags SHALL be 0.
REQ-038 While rst = 0, StallCount = 0.
REQ-039 While rst = 0, all stall and flush outputs = 0 and ForwardAE = ForwardBE = 00.
REQ-040 Reset asserted mid-stall or mid-freeze SHALL clear all state immediately; no pending flush survives reset.
REQ-041 On the first rising edge after rst goes to 1, normal advance SHALL resume.

Verification
REQ-042 Scenario: lw x5 then add x6,x5,x7 -> one cycle of StallF = StallD = FlushE = 1; next cycle ForwardAE = 01; StallCount = 1.
REQ-043 Scenario: add x3,.. then sub x4,x3,x3 -> ForwardAE = ForwardBE = 10; no stall.
REQ-044 Scenario: add x3 followed two instructions later by an instruction reading x3 -> ForwardAE = 01.
REQ-045 Scenario: writes to x3 in both M and W, E reads x3 -> ForwardAE = 10.
REQ-046 Scenario: load-use condition with PCSrcE = 1 in the same cycle -> FlushD = FlushE = 1, StallD = 0, StallCount unchanged.
REQ-047 Scenario: x0 as load destination with x0 consumer -> no stall, ForwardAE = 00.
REQ-048 Scenario: MemReady = 0 for 3 cycles with PCSrcE = 1 -> all stalls = 1 and flushes = 0 for 3 cycles; flush on the 4th cycle; StallCount = 3.
REQ-049 Scenario: StallCount preloaded near saturation and stalled past 0xFFFF -> holds 0xFFFF.
REQ-050 Scenario: rst = 0 pulse during a freeze -> all outputs return to their reset values at once.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, branch flush, operand forwarding
// and memory freeze, tracked through shadow tags of the E, M and W stages.
module hazard_ctrl #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] rs1D,
  input  logic [REG_ADDR_W-1:0] rs2D,
  input  logic [REG_ADDR_W-1:0] rdD,
  input  logic                  RegWriteD,
  input  logic                  ResultSrcD,
  input  logic                  PCSrcE,
  input  logic                  MemReady,
  output logic                  StallF,
  output logic                  StallD,
  output logic                  StallE,
  output logic                  StallM,
  output logic                  StallW,
  output logic                  FlushD,
  output logic                  FlushE,
  output logic [1:0]            ForwardAE,
  output logic [1:0]            ForwardBE,
  output logic [CNT_W-1:0]      StallCount
);

  localparam logic [REG_ADDR_W-1:0] X0      = {REG_ADDR_W{1'b0}};
  localparam logic [CNT_W-1:0]      CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]      CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // A writer only produces a hazard if it really writes and is not x0
  function automatic logic dep_hit(input logic wr,
                                   input logic [REG_ADDR_W-1:0] rd,
                                   input logic [REG_ADDR_W-1:0] rs);
    return wr && (rd != X0) && (rd == rs);
  endfunction

  function automatic logic [1:0] fwd_sel(input logic m_hit, input logic w_hit);
    logic [1:0] sel;
    if (m_hit) begin
      sel = 2'b10;
    end else if (w_hit) begin
      sel = 2'b01;
    end else begin
      sel = 2'b00;
    end
    return sel;
  endfunction

  logic [REG_ADDR_W-1:0] e_rs1_r, e_rs2_r, e_rd_r, m_rd_r, w_rd_r;
  logic                  e_regwrite_r, e_load_r, m_regwrite_r, w_regwrite_r;
  logic [CNT_W-1:0]      stall_count_r;

  logic       freeze_s;
  logic       load_use_s;
  logic       bubble_e_s;
  logic [1:0] fwd_a_s;
  logic [1:0] fwd_b_s;

  // Hazard detection from shadow tags and the Decode operands
  always_comb begin
    freeze_s   = !MemReady;
    load_use_s = e_load_r && (e_rd_r != X0) && ((e_rd_r == rs1D) || (e_rd_r == rs2D));
    bubble_e_s = PCSrcE || load_use_s;
    fwd_a_s    = fwd_sel(dep_hit(m_regwrite_r, m_rd_r, e_rs1_r),
                         dep_hit(w_regwrite_r, w_rd_r, e_rs1_r));
    fwd_b_s    = fwd_sel(dep_hit(m_regwrite_r, m_rd_r, e_rs2_r),
                         dep_hit(w_regwrite_r, w_rd_r, e_rs2_r));
  end

  // Stall/flush/forward outputs; a freeze overrides everything, a taken branch squashes a load-use stall
  always_comb begin
    StallF    = 1'b0;
    StallD    = 1'b0;
    StallE    = 1'b0;
    StallM    = 1'b0;
    StallW    = 1'b0;
    FlushD    = 1'b0;
    FlushE    = 1'b0;
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    if (!rst) begin
      StallF = 1'b0;
      FlushE = 1'b0;
    end else if (freeze_s) begin
      StallF    = 1'b1;
      StallD    = 1'b1;
      StallE    = 1'b1;
      StallM    = 1'b1;
      StallW    = 1'b1;
      ForwardAE = fwd_a_s;
      ForwardBE = fwd_b_s;
    end else begin
      StallF    = load_use_s && !PCSrcE;
      StallD    = load_use_s && !PCSrcE;
      FlushD    = PCSrcE;
      FlushE    = bubble_e_s;
      ForwardAE = fwd_a_s;
      ForwardBE = fwd_b_s;
    end
  end

  // Shadow pipeline tags: hold during a freeze, otherwise advance with a bubble into E when needed
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      e_rs1_r      <= X0;
      e_rs2_r      <= X0;
      e_rd_r       <= X0;
      e_regwrite_r <= 1'b0;
      e_load_r     <= 1'b0;
      m_rd_r       <= X0;
      m_regwrite_r <= 1'b0;
      w_rd_r       <= X0;
      w_regwrite_r <= 1'b0;
    end else if (freeze_s) begin
      e_rs1_r      <= e_rs1_r;
      e_rs2_r      <= e_rs2_r;
      e_rd_r       <= e_rd_r;
      e_regwrite_r <= e_regwrite_r;
      e_load_r     <= e_load_r;
      m_rd_r       <= m_rd_r;
      m_regwrite_r <= m_regwrite_r;
      w_rd_r       <= w_rd_r;
      w_regwrite_r <= w_regwrite_r;
    end else begin
      w_rd_r       <= m_rd_r;
      w_regwrite_r <= m_regwrite_r;
      m_rd_r       <= e_rd_r;
      m_regwrite_r <= e_regwrite_r;
      if (bubble_e_s) begin
        e_rs1_r      <= X0;
        e_rs2_r      <= X0;
        e_rd_r       <= X0;
        e_regwrite_r <= 1'b0;
        e_load_r     <= 1'b0;
      end else begin
        e_rs1_r      <= rs1D;
        e_rs2_r      <= rs2D;
        e_rd_r       <= rdD;
        e_regwrite_r <= RegWriteD;
        e_load_r     <= ResultSrcD;
      end
    end
  end

  // Saturating count of cycles with Decode held
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_count_r <= {CNT_W{1'b0}};
    end else if (StallD && (stall_count_r != CNT_MAX)) begin
      stall_count_r <= stall_count_r + CNT_ONE;
    end else begin
      stall_count_r <= stall_count_r;
    end
  end

  assign StallCount = stall_count_r;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: each scenario pushes hand-derived expected
// outputs as stimulus is driven and pops them when the outputs are sampled.
module tb_hazard_ctrl;

  logic        clk, rst;
  logic [4:0]  rs1D, rs2D, rdD;
  logic        RegWriteD, ResultSrcD, PCSrcE, MemReady;
  logic        StallF, StallD, StallE, StallM, StallW, FlushD, FlushE;
  logic [1:0]  ForwardAE, ForwardBE;
  logic [15:0] StallCount;

  typedef struct packed {
    logic       rst;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       rw;
    logic       ld;
    logic       pc;
    logic       mr;
  } stim_t;
  typedef logic [26:0] exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  hazard_ctrl #(.REG_ADDR_W(5), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .rs1D(rs1D), .rs2D(rs2D), .rdD(rdD),
    .RegWriteD(RegWriteD), .ResultSrcD(ResultSrcD), .PCSrcE(PCSrcE), .MemReady(MemReady),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM), .StallW(StallW),
    .FlushD(FlushD), .FlushE(FlushE), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .StallCount(StallCount)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic stim_t st(input logic r, input logic [4:0] a, input logic [4:0] b,
                               input logic [4:0] d, input logic w, input logic l,
                               input logic p, input logic m);
    return {r, a, b, d, w, l, p, m};
  endfunction

  // expected vector: {StallF,D,E,M,W}, {FlushD,FlushE}, ForwardAE, ForwardBE, StallCount
  function automatic exp_t ex(input logic [4:0] s, input logic [1:0] f, input logic [1:0] fa,
                              input logic [1:0] fb, input logic [15:0] c);
    return {s, f, fa, fb, c};
  endfunction

  // reset row keeps PCSrcE high and MemReady low to show both are masked
  localparam stim_t RST  = {1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0};
  localparam stim_t NOP  = {1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1};
  localparam stim_t FRZ  = {1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0};
  localparam stim_t ADD3 = {1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 1'b0, 1'b1};
  localparam stim_t LW5  = {1'b1, 5'd1, 5'd0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b1};
  localparam exp_t  Z    = 27'd0;

  task automatic drive(input stim_t s, input exp_t e);
    @(negedge clk);
    rst        = s.rst;
    rs1D       = s.rs1;
    rs2D       = s.rs2;
    rdD        = s.rd;
    RegWriteD  = s.rw;
    ResultSrcD = s.ld;
    PCSrcE     = s.pc;
    MemReady   = s.mr;
    sb.push_back(e);
    #2;
  endtask

  task automatic test_reset();
    stim_t s[$]; exp_t e[$]; exp_t got, want;
    s.push_back(RST);                                                    e.push_back(Z);
    s.push_back(st(1'b0, 5'd5, 5'd5, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0));    e.push_back(Z);
    for (int i = 0; i < s.size(); i++) begin
      drive(s[i], e[i]);
      want = sb.pop_front();
      got  = {StallF, StallD, StallE, StallM, StallW, FlushD, FlushE, ForwardAE, ForwardBE, StallCount};
      total++;
      if (got !== want) begin bad++; $display("FAIL reset[%0d] got=%h want=%h", i, got, want); end
    end
  endtask

  task automatic test_load_use();
    stim_t s[$]; exp_t e[$]; exp_t got, want;
    s.push_back(RST);                                                  e.push_back(Z);
    s.push_back(LW5);                                                  e.push_back(Z);
    s.push_back(st(1'b1, 5'd5, 5'd7, 5'd6, 1'b1, 1'b0, 1'b0, 1'b1));  e.push_back(ex(5'b11000, 2'b01, 2'b00, 2'b00, 16'd0));
    s.push_back(st(1'b1, 5'd5, 5'd7, 5'd6, 1'b1, 1'b0, 1'b0, 1'b1));  e.push_back(ex(5'b00000, 2'b00, 2'b00, 2'b00, 16'd1));
    s.push_back(NOP);                                                  e.push_back(ex(5'b00000, 2'b00, 2'b01, 2'b00, 16'd1));
    for (int i = 0; i < s.size(); i++) begin
      drive(s[i], e[i]);
      want = sb.pop_front();
      got  = {StallF, StallD, StallE, StallM, StallW, FlushD, FlushE, ForwardAE, ForwardBE, StallCount};
      total++;
      if (got !== want) begin bad++; $display("FAIL load_use[%0d] got=%h want=%h", i, got, want); end
    end
  endtask

  task automatic test_forward();
    stim_t s[$]; exp_t e[$]; exp_t got, want;
    // M-stage forward on both operands
    s.push_back(RST);                                                  e.push_back(Z);
    s.push_back(ADD3);                                                 e.push_back(Z);
    s.push_back(st(1'b1, 5'd3, 5'd3, 5'd4, 1'b1, 1'b0, 1'b0, 1'b1));  e.push_back(Z);
    s.push_back(NOP);                                                  e.push_back(ex(5'b0, 2'b00, 2'b10, 2'b10, 16'd0));
    // W-stage forward two instructions later
    s.push_back(RST);                                                  e.push_back(Z);
    s.push_back(ADD3);                                                 e.push_back(Z);
    s.push_back(NOP);                                                  e.push_back(Z);
    s.push_back(st(1'b1, 5'd3, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b1));  e.push_back(Z);
    s.push_back(NOP);                                                  e.push_back(ex(5'b0, 2'b00, 2'b01, 2'b00, 16'd0));
    // x3 written in both M and W: M wins
    s.push_back(RST);                                                  e.push_back(Z);
    s.push_back(ADD3);                                                 e.push_back(Z);
    s.push_back(ADD3);                                                 e.push_back(Z);
    s.push_back(st(1'b1, 5'd3, 5'd3, 5'd6, 1'b1, 1'b0, 1'b0, 1'b1));  e.push_back(Z);
    s.push_back(NOP);                                                  e.push_back(ex(5'b0, 2'b00, 2'b10, 2'b10, 16'd0));
    for (int i = 0; i < s.size(); i++) begin
      drive(s[i], e[i]);
      want = sb.pop_front();
      got  = {StallF, StallD, StallE, StallM, StallW, FlushD, FlushE, ForwardAE, ForwardBE, StallCount};
      total++;
      if (got !== want) begin bad++; $display("FAIL forward[%0d] got=%h want=%h", i, got, want); end
    end
  endtask

  task automatic test_flush_and_x0();
    stim_t s[$]; exp_t e[$]; exp_t got, want;
    // taken branch squashes a load-use stall
    s.push_back(RST);                                                  e.push_back(Z);
    s.push_back(LW5);                                                  e.push_back(Z);
    s.push_back(st(1'b1, 5'd5, 5'd7, 5'd6, 1'b1, 1'b0, 1'b1, 1'b1));  e.push_back(ex(5'b0, 2'b11, 2'b00, 2'b00, 16'd0));
    s.push_back(NOP);                                                  e.push_back(Z);
    // load into x0 followed by an x0 consumer
    s.push_back(RST);                                                  e.push_back(Z);
    s.push_back(st(1'b1, 5'd1, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b1));  e.push_back(Z);
    s.push_back(st(1'b1, 5'd0, 5'd0, 5'd6, 1'b1, 1'b0, 1'b0, 1'b1));  e.push_back(Z);
    s.push_back(NOP);                                                  e.push_back(Z);
    for (int i = 0; i < s.size(); i++) begin
      drive(s[i], e[i]);
      want = sb.pop_front();
      got  = {StallF, StallD, StallE, StallM, StallW, FlushD, FlushE, ForwardAE, ForwardBE, StallCount};
      total++;
      if (got !== want) begin bad++; $display("FAIL flush_x0[%0d] got=%h want=%h", i, got, want); end
    end
  endtask

  task automatic test_freeze();
    stim_t s[$]; exp_t e[$]; exp_t got, want;
    stim_t rd3;
    rd3 = st(1'b1, 5'd3, 5'd0, 5'd4, 1'b1, 1'b0, 1'b0, 1'b1);
    s.push_back(RST);   e.push_back(Z);
    s.push_back(ADD3);  e.push_back(Z);
    s.push_back(rd3);   e.push_back(Z);
    for (int k = 0; k < 3; k++) begin
      s.push_back(FRZ); e.push_back(ex(5'b11111, 2'b00, 2'b10, 2'b00, 16'(k)));
    end
    s.push_back(st(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1));  e.push_back(ex(5'b0, 2'b11, 2'b10, 2'b00, 16'd3));
    s.push_back(NOP);   e.push_back(ex(5'b0, 2'b00, 2'b00, 2'b00, 16'd3));
    // reset during a freeze, then normal advance resumes
    s.push_back(RST);   e.push_back(Z);
    s.push_back(ADD3);  e.push_back(Z);
    s.push_back(rd3);   e.push_back(Z);
    s.push_back(FRZ);   e.push_back(ex(5'b11111, 2'b00, 2'b10, 2'b00, 16'd0));
    s.push_back(FRZ);   e.push_back(ex(5'b11111, 2'b00, 2'b10, 2'b00, 16'd1));
    s.push_back(RST);   e.push_back(Z);
    s.push_back(NOP);   e.push_back(Z);
    s.push_back(ADD3);  e.push_back(Z);
    s.push_back(rd3);   e.push_back(Z);
    s.push_back(NOP);   e.push_back(ex(5'b0, 2'b00, 2'b10, 2'b00, 16'd0));
    for (int i = 0; i < s.size(); i++) begin
      drive(s[i], e[i]);
      want = sb.pop_front();
      got  = {StallF, StallD, StallE, StallM, StallW, FlushD, FlushE, ForwardAE, ForwardBE, StallCount};
      total++;
      if (got !== want) begin bad++; $display("FAIL freeze[%0d] got=%h want=%h", i, got, want); end
    end
  endtask

  task automatic test_saturate();
    stim_t s[$]; exp_t e[$]; exp_t got, want;
    // 65533 unchecked freeze cycles follow the reset row, leaving the count at 0xFFFD
    s.push_back(RST);   e.push_back(Z);
    for (int k = 0; k < 65533; k++) begin
      s.push_back(FRZ); e.push_back(ex(5'b11111, 2'b00, 2'b00, 2'b00, 16'(k)));
    end
    s.push_back(FRZ);   e.push_back(ex(5'b11111, 2'b00, 2'b00, 2'b00, 16'hFFFD));
    s.push_back(FRZ);   e.push_back(ex(5'b11111, 2'b00, 2'b00, 2'b00, 16'hFFFE));
    s.push_back(FRZ);   e.push_back(ex(5'b11111, 2'b00, 2'b00, 2'b00, 16'hFFFF));
    s.push_back(FRZ);   e.push_back(ex(5'b11111, 2'b00, 2'b00, 2'b00, 16'hFFFF));
    s.push_back(FRZ);   e.push_back(ex(5'b11111, 2'b00, 2'b00, 2'b00, 16'hFFFF));
    s.push_back(NOP);   e.push_back(ex(5'b00000, 2'b00, 2'b00, 2'b00, 16'hFFFF));
    for (int i = 0; i < s.size(); i++) begin
      drive(s[i], e[i]);
      want = sb.pop_front();
      got  = {StallF, StallD, StallE, StallM, StallW, FlushD, FlushE, ForwardAE, ForwardBE, StallCount};
      if (i == 0 || i > 65533) begin
        total++;
        if (got !== want) begin bad++; $display("FAIL saturate[%0d] got=%h want=%h", i, got, want); end
      end
    end
  endtask

  initial begin
    rst        = 1'b0;
    rs1D       = 5'd0;
    rs2D       = 5'd0;
    rdD        = 5'd0;
    RegWriteD  = 1'b0;
    ResultSrcD = 1'b0;
    PCSrcE     = 1'b0;
    MemReady   = 1'b1;
    test_reset();
    test_load_use();
    test_forward();
    test_flush_and_x0();
    test_freeze();
    test_saturate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
